// File: rtl/clock_enable_gen.sv
// NUM_CH runtime-programmable tick/square-wave dividers plus a free-running count.
// Define CLOCK_ENABLE_GEN_SYNC_EN to add the sync_clr phase-alignment input.
module clock_enable_gen #(
   parameter int          NUM_CH      = 4,
   parameter int          DIV_W       = 32,
   parameter int unsigned DEFAULT_DIV = 49_999_999,
   parameter int          FREE_W      = 32,
   localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
`ifdef CLOCK_ENABLE_GEN_SYNC_EN
   input  logic              sync_clr,
`endif
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq_out,
   output logic [NUM_CH-1:0] cfg_pending,
   output logic [FREE_W-1:0] free_count
);

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

   logic              align;
   logic [FREE_W-1:0] free_reg;

`ifdef CLOCK_ENABLE_GEN_SYNC_EN
   assign align = sync_clr;
`else
   assign align = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         free_reg <= '0;
      else
         free_reg <= free_reg + FREE_W'(1);
   end

   assign free_count = free_reg;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [DIV_W-1:0] cnt_reg;
         logic [DIV_W-1:0] active_reg;
         logic [DIV_W-1:0] pending_reg;
         logic [DIV_W-1:0] load_val;
         logic             pend_reg;
         logic             tick_reg;
         logic             sq_reg;
         logic             wr_hit;

         // Out-of-range channel numbers never match, so such writes are dropped.
         assign wr_hit   = cfg_wr && (32'(cfg_ch) == gi);
         assign load_val = pend_reg ? pending_reg : active_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt_reg     <= DEF_DIV;
               active_reg  <= DEF_DIV;
               pending_reg <= DEF_DIV;
               pend_reg    <= 1'b0;
               tick_reg    <= 1'b0;
               sq_reg      <= 1'b0;
            end else begin
               tick_reg <= 1'b0;
               if (align) begin
                  cnt_reg    <= load_val;
                  active_reg <= load_val;
                  pend_reg   <= 1'b0;
                  sq_reg     <= 1'b0;
               end else if (!ch_en[gi]) begin
                  cnt_reg    <= load_val;
                  active_reg <= load_val;
                  pend_reg   <= 1'b0;
               end else if (cnt_reg == '0) begin
                  tick_reg   <= 1'b1;
                  sq_reg     <= ~sq_reg;
                  cnt_reg    <= load_val;
                  active_reg <= load_val;
                  pend_reg   <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg - DIV_W'(1);
               end
               // A write landing on a reload edge survives as pending for the next boundary.
               if (wr_hit) begin
                  pending_reg <= cfg_div;
                  pend_reg    <= 1'b1;
               end
            end
         end

         assign tick[gi]        = tick_reg;
         assign sq_out[gi]      = sq_reg;
         assign cfg_pending[gi] = pend_reg;
      end
   endgenerate

endmodule

// File: tb/tb_clock_enable_gen.sv
// Scoreboard bench for clock_enable_gen: 3 channels, 8-bit dividers, reset divide of 4.
module tb_clock_enable_gen;

   typedef struct packed {
      logic [2:0] t;
      logic [2:0] s;
      logic [2:0] p;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
`ifdef CLOCK_ENABLE_GEN_SYNC_EN
   logic       sync_clr = 1'b0;
`endif
   logic [2:0] ch_en = 3'b111;
   logic       cfg_wr = 1'b0;
   logic [1:0] cfg_ch = 2'd0;
   logic [7:0] cfg_div = 8'd0;
   logic [2:0] tick;
   logic [2:0] sq_out;
   logic [2:0] cfg_pending;
   logic [7:0] free_count;

   int         total = 0;
   int         bad = 0;
   exp_t       exp_q[$];
   exp_t       e;
   logic [2:0] sq_model;

   clock_enable_gen #(
      .NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(4), .FREE_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
`ifdef CLOCK_ENABLE_GEN_SYNC_EN
      .sync_clr(sync_clr),
`endif
      .ch_en(ch_en),
      .cfg_wr(cfg_wr),
      .cfg_ch(cfg_ch),
      .cfg_div(cfg_div),
      .tick(tick),
      .sq_out(sq_out),
      .cfg_pending(cfg_pending),
      .free_count(free_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic bit periodic(int k, int first, int per);
      return (k >= first) && ((k - first) % per == 0);
   endfunction

   // Expected square wave is the running parity of expected ticks.
   task automatic push_exp(input logic [2:0] t, input logic [2:0] p);
      sq_model = sq_model ^ t;
      exp_q.push_back('{t: t, s: sq_model, p: p});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input logic [1:0] ch, input logic [7:0] d);
      cfg_wr  = 1'b1;
      cfg_ch  = ch;
      cfg_div = d;
   endtask

   // Leaves the bench at cycle 0; the next posedge is edge 1.
   task automatic do_reset();
      cfg_wr = 1'b0;
`ifdef CLOCK_ENABLE_GEN_SYNC_EN
      sync_clr = 1'b0;
`endif
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      sq_model = 3'b000;
   endtask

   task automatic test_reset();
      ch_en = 3'b111;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({tick, sq_out, cfg_pending} !== 9'b0) begin
         bad++;
         $display("FAIL reset_outs got=%b_%b_%b want=0_0_0", tick, sq_out, cfg_pending);
      end
      total++;
      if (free_count !== 8'd0) begin
         bad++;
         $display("FAIL reset_free got=%0d want=0", free_count);
      end
   endtask

   task automatic test_default();
      ch_en = 3'b111;
      do_reset();
      for (int k = 1; k <= 20; k++)
         push_exp(periodic(k, 5, 5) ? 3'b111 : 3'b000, 3'b000);
      for (int k = 1; k <= 20; k++) begin
         step();
         e = exp_q.pop_front();
         total++;
         if ({tick, sq_out, cfg_pending} !== e) begin
            bad++;
            $display("FAIL default cyc=%0d got=%b_%b_%b want=%b_%b_%b", k, tick, sq_out, cfg_pending, e.t, e.s, e.p);
         end
         total++;
         if (free_count !== 8'(k)) begin
            bad++;
            $display("FAIL default_free cyc=%0d got=%0d want=%0d", k, free_count, k);
         end
      end
   endtask

   task automatic test_cfg_update();
      ch_en = 3'b111;
      do_reset();
      for (int k = 1; k <= 18; k++) begin
         logic t1;
         t1 = (k == 5) || (k == 10) || (k > 10 && k % 2 == 0);
         push_exp({periodic(k, 5, 5), t1, periodic(k, 5, 5)}, {1'b0, (k == 8 || k == 9), 1'b0});
      end
      for (int k = 1; k <= 18; k++) begin
         step();
         e = exp_q.pop_front();
         total++;
         if ({tick, sq_out, cfg_pending} !== e) begin
            bad++;
            $display("FAIL cfg_update cyc=%0d got=%b_%b_%b want=%b_%b_%b", k, tick, sq_out, cfg_pending, e.t, e.s, e.p);
         end
         if (k == 7) write_cfg(2'd1, 8'd1);
         if (k == 8) cfg_wr = 1'b0;
      end
   endtask

   // Last write wins, write on a reload edge, and an out-of-range channel.
   task automatic test_boundary();
      ch_en = 3'b111;
      do_reset();
      for (int k = 1; k <= 18; k++) begin
         logic t0, t2;
         t0 = (k == 5) || (k > 5 && k % 2 == 1);
         t2 = (k == 5) || (k == 10) || (k > 10 && (k - 10) % 3 == 0);
         push_exp({t2, periodic(k, 5, 5), t0}, {(k >= 5 && k <= 9), 1'b0, (k == 3 || k == 4)});
      end
      for (int k = 1; k <= 18; k++) begin
         step();
         e = exp_q.pop_front();
         total++;
         if ({tick, sq_out, cfg_pending} !== e) begin
            bad++;
            $display("FAIL boundary cyc=%0d got=%b_%b_%b want=%b_%b_%b", k, tick, sq_out, cfg_pending, e.t, e.s, e.p);
         end
         case (k)
            2: write_cfg(2'd0, 8'd2);
            3: write_cfg(2'd0, 8'd1);
            4: write_cfg(2'd2, 8'd2);
            5: cfg_wr = 1'b0;
            6: write_cfg(2'd3, 8'd0);
            7: cfg_wr = 1'b0;
            default: ;
         endcase
      end
   endtask

   task automatic test_zero_div();
      ch_en = 3'b011;
      do_reset();
      for (int k = 1; k <= 12; k++)
         push_exp({(k >= 5), periodic(k, 5, 5), periodic(k, 5, 5)}, {(k == 2), 2'b00});
      for (int k = 1; k <= 12; k++) begin
         step();
         e = exp_q.pop_front();
         total++;
         if ({tick, sq_out, cfg_pending} !== e) begin
            bad++;
            $display("FAIL zero_div cyc=%0d got=%b_%b_%b want=%b_%b_%b", k, tick, sq_out, cfg_pending, e.t, e.s, e.p);
         end
         if (k == 1) write_cfg(2'd2, 8'd0);
         if (k == 2) cfg_wr = 1'b0;
         if (k == 4) ch_en = 3'b111;
      end
   endtask

   task automatic test_disable();
      ch_en = 3'b111;
      do_reset();
      for (int k = 1; k <= 22; k++)
         push_exp({periodic(k, 5, 5), periodic(k, 5, 5), (k == 5 || k == 15 || k == 20)}, 3'b000);
      for (int k = 1; k <= 22; k++) begin
         step();
         e = exp_q.pop_front();
         total++;
         if ({tick, sq_out, cfg_pending} !== e) begin
            bad++;
            $display("FAIL disable cyc=%0d got=%b_%b_%b want=%b_%b_%b", k, tick, sq_out, cfg_pending, e.t, e.s, e.p);
         end
         if (k == 7) ch_en = 3'b110;
         if (k == 10) ch_en = 3'b111;
      end
   endtask

   task automatic test_reset_mid();
      ch_en = 3'b111;
      do_reset();
      for (int k = 1; k <= 7; k++)
         push_exp(periodic(k, 5, 5) ? 3'b111 : 3'b000, {1'b0, (k == 7), 1'b0});
      for (int k = 1; k <= 7; k++) begin
         step();
         e = exp_q.pop_front();
         total++;
         if ({tick, sq_out, cfg_pending} !== e) begin
            bad++;
            $display("FAIL reset_mid_pre cyc=%0d got=%b_%b_%b want=%b_%b_%b", k, tick, sq_out, cfg_pending, e.t, e.s, e.p);
         end
         if (k == 6) write_cfg(2'd1, 8'd1);
         if (k == 7) cfg_wr = 1'b0;
      end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if ({tick, sq_out, cfg_pending} !== 9'b0) begin
         bad++;
         $display("FAIL reset_mid_async got=%b_%b_%b want=0_0_0", tick, sq_out, cfg_pending);
      end
      total++;
      if (free_count !== 8'd0) begin
         bad++;
         $display("FAIL reset_mid_free got=%0d want=0", free_count);
      end
      #4;
      reset = 1'b1;
      sq_model = 3'b000;
      for (int k = 1; k <= 12; k++)
         push_exp(periodic(k, 5, 5) ? 3'b111 : 3'b000, 3'b000);
      for (int k = 1; k <= 12; k++) begin
         step();
         e = exp_q.pop_front();
         total++;
         if ({tick, sq_out, cfg_pending} !== e) begin
            bad++;
            $display("FAIL reset_mid_post cyc=%0d got=%b_%b_%b want=%b_%b_%b", k, tick, sq_out, cfg_pending, e.t, e.s, e.p);
         end
      end
   endtask

   task automatic test_wrap();
      ch_en = 3'b111;
      do_reset();
      for (int k = 1; k <= 257; k++) begin
         step();
         if (k >= 255) begin
            total++;
            if (free_count !== 8'(k)) begin
               bad++;
               $display("FAIL free_wrap cyc=%0d got=%0d want=%0d", k, free_count, k % 256);
            end
         end
      end
   endtask

`ifdef CLOCK_ENABLE_GEN_SYNC_EN
   task automatic test_sync();
      ch_en = 3'b000;
      do_reset();
      for (int k = 21; k <= 40; k++)
         push_exp({1'b0, (k > 21 && (k - 21) % 8 == 0), (k > 21 && (k - 21) % 4 == 0)}, 3'b000);
      for (int k = 1; k <= 40; k++) begin
         step();
         if (k >= 21) begin
            e = exp_q.pop_front();
            total++;
            if ({tick, sq_out, cfg_pending} !== e) begin
               bad++;
               $display("FAIL sync cyc=%0d got=%b_%b_%b want=%b_%b_%b", k, tick, sq_out, cfg_pending, e.t, e.s, e.p);
            end
         end
         case (k)
            1: write_cfg(2'd0, 8'd3);
            2: write_cfg(2'd1, 8'd7);
            3: cfg_wr = 1'b0;
            4: ch_en = 3'b001;
            6: ch_en = 3'b011;
            20: sync_clr = 1'b1;
            21: sync_clr = 1'b0;
            default: ;
         endcase
      end
   endtask
`endif

   initial begin
      sq_model = 3'b000;
      test_reset();
      test_default();
      test_cfg_update();
      test_boundary();
      test_zero_div();
      test_disable();
      test_reset_mid();
      test_wrap();
`ifdef CLOCK_ENABLE_GEN_SYNC_EN
      test_sync();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
